// File: rtl/menu_text_ctrl.sv
// Registered 16x2 LCD text composer: owns scent/timer selection, runs the BCD
// countdown with a blinking colon, and strobes upd whenever the rows change.
module menu_text_ctrl #(
    parameter int TICK_DIV  = 50_000_000,
    parameter int BLINK_DIV = 25_000_000,
    parameter int T0_MIN    = 30,
    parameter int T1_MIN    = 60,
    parameter int T2_MIN    = 120
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         sw,
    input  logic         btn_l,
    input  logic         btn_r,
    input  logic         btn_u,
    input  logic         btn_d,
    input  logic         ld_valid,
    input  logic [1:0]   ld_scent,
    input  logic [1:0]   ld_timer,
    input  logic         start,
    input  logic         cancel,
    input  logic [3:0]   temperature10,
    input  logic [3:0]   temperature0,
    input  logic [3:0]   humidity10,
    input  logic [3:0]   humidity0,
    output logic [127:0] row1,
    output logic [127:0] row2,
    output logic         upd,
    output logic         running,
    output logic         done
);

    localparam int TW = $clog2(TICK_DIV + 1);
    localparam int BW = $clog2(BLINK_DIV + 1);

    function automatic logic [11:0] toBcd(input int n);
        return {4'(n / 100 % 10), 4'(n / 10 % 10), 4'(n % 10)};
    endfunction

    localparam logic [11:0] T0_BCD = toBcd(T0_MIN);
    localparam logic [11:0] T1_BCD = toBcd(T1_MIN);
    localparam logic [11:0] T2_BCD = toBcd(T2_MIN);

    typedef enum logic {S_IDLE, S_RUN} state_t;

    state_t          r_state, w_stateNext;
    logic   [1:0]    r_scent, r_timer;
    logic   [11:0]   r_min;
    logic   [7:0]    r_sec;
    logic   [TW-1:0] r_tick;
    logic   [BW-1:0] r_blink;
    logic            r_phase;
    logic   [127:0]  r_row1, r_row2;
    logic            r_upd, r_done;
    logic            w_done, w_tickHit, w_blinkHit, w_lastSec;
    logic   [11:0]   w_loadMin;
    logic   [127:0]  w_row1, w_row2;
    logic   [7:0]    w_hund, w_tens, w_sep;

    function automatic logic [1:0] wrapInc(input logic [1:0] i);
        return (i >= 2'd2) ? 2'd0 : i + 2'd1;
    endfunction

    function automatic logic [1:0] wrapDec(input logic [1:0] i);
        return (i == 2'd0) ? 2'd2 : i - 2'd1;
    endfunction

    function automatic logic [7:0] secDec(input logic [7:0] s);
        if (s == 8'h00)      return 8'h59;
        if (s[3:0] == 4'd0)  return {s[7:4] - 4'd1, 4'd9};
        return s - 8'd1;
    endfunction

    function automatic logic [11:0] minDec(input logic [11:0] m);
        if (m[3:0] != 4'd0)  return m - 12'd1;
        if (m[7:4] != 4'd0)  return {m[11:8], m[7:4] - 4'd1, 4'd9};
        return {m[11:8] - 4'd1, 8'h99};
    endfunction

    function automatic logic [7:0] digitChar(input logic [3:0] d);
        return (d > 4'd9) ? 8'h3F : {4'h3, d};
    endfunction

    function automatic logic [71:0] scentName(input logic [1:0] s);
        case (s)
            2'd1:    return "Woody    ";
            2'd2:    return "Citrus   ";
            default: return "Cotton   ";
        endcase
    endfunction

    assign w_tickHit  = (r_tick == TW'(TICK_DIV - 1));
    assign w_blinkHit = (r_blink == BW'(BLINK_DIV - 1));
    assign w_lastSec  = (r_min == 12'h000) && (r_sec == 8'h01);

    always_comb begin
        case (r_timer)
            2'd1:    w_loadMin = T1_BCD;
            2'd2:    w_loadMin = T2_BCD;
            default: w_loadMin = T0_BCD;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) r_state <= S_IDLE;
        else      r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = r_state;
        w_done      = 1'b0;
        case (r_state)
            S_IDLE: if (start) w_stateNext = S_RUN;
            S_RUN: begin
                if (cancel) begin
                    w_stateNext = S_IDLE;
                end else if (w_tickHit && w_lastSec) begin
                    w_stateNext = S_IDLE;
                    w_done      = 1'b1;
                end
            end
            default: w_stateNext = S_IDLE;
        endcase
    end

    // Bluetooth load beats buttons; selections freeze while counting down.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_scent <= 2'd0;
            r_timer <= 2'd0;
        end else if (r_state == S_IDLE) begin
            if (ld_valid) begin
                r_scent <= (ld_scent == 2'd3) ? 2'd2 : ld_scent;
                r_timer <= (ld_timer == 2'd3) ? 2'd2 : ld_timer;
            end else begin
                if (btn_r && !btn_l)      r_scent <= wrapInc(r_scent);
                else if (btn_l && !btn_r) r_scent <= wrapDec(r_scent);
                if (btn_u && !btn_d)      r_timer <= wrapInc(r_timer);
                else if (btn_d && !btn_u) r_timer <= wrapDec(r_timer);
            end
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_min   <= 12'h000;
            r_sec   <= 8'h00;
            r_tick  <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
        end else if (r_state == S_RUN && w_stateNext == S_RUN) begin
            if (w_tickHit) begin
                r_tick <= '0;
                r_sec  <= secDec(r_sec);
                if (r_sec == 8'h00) r_min <= minDec(r_min);
            end else begin
                r_tick <= r_tick + 1'b1;
            end
            if (w_blinkHit) begin
                r_blink <= '0;
                r_phase <= ~r_phase;
            end else begin
                r_blink <= r_blink + 1'b1;
            end
        end else begin
            r_tick  <= '0;
            r_blink <= '0;
            r_phase <= 1'b0;
            if (r_state == S_IDLE && start) begin
                r_min <= w_loadMin;
                r_sec <= 8'h00;
            end else if (w_done) begin
                r_min <= 12'h000;
                r_sec <= 8'h00;
            end
        end
    end

    assign w_hund = (w_loadMin[11:8] == 4'd0) ? 8'h20 : digitChar(w_loadMin[11:8]);
    assign w_tens = (w_loadMin[11:4] == 8'd0) ? 8'h20 : digitChar(w_loadMin[7:4]);
    assign w_sep  = r_phase ? 8'h20 : 8'h3A;

    // The sensor page only changes what is shown; state keeps running beneath it.
    always_comb begin
        w_row1 = {"Scent: ", scentName(r_scent)};
        w_row2 = {"Timer: ", w_hund, w_tens, digitChar(w_loadMin[3:0]), "min   "};
        if (sw) begin
            w_row1 = {"Temp: ", digitChar(temperature10), digitChar(temperature0), "'C      "};
            w_row2 = {"Humi: ", digitChar(humidity10), digitChar(humidity0), "%       "};
        end else if (r_state == S_RUN) begin
            w_row1 = {"Run: ", scentName(r_scent), "  "};
            w_row2 = {"Left: ", digitChar(r_min[11:8]), digitChar(r_min[7:4]),
                      digitChar(r_min[3:0]), w_sep, digitChar(r_sec[7:4]),
                      digitChar(r_sec[3:0]), "    "};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            r_row1 <= {16{8'h20}};
            r_row2 <= {16{8'h20}};
            r_upd  <= 1'b0;
            r_done <= 1'b0;
        end else begin
            r_row1 <= w_row1;
            r_row2 <= w_row2;
            r_upd  <= (w_row1 != r_row1) || (w_row2 != r_row2);
            r_done <= w_done;
        end
    end

    assign row1    = r_row1;
    assign row2    = r_row2;
    assign upd     = r_upd;
    assign done    = r_done;
    assign running = (r_state == S_RUN);

endmodule

// File: tb/tb_menu_text_ctrl.sv
// Scoreboard bench for menu_text_ctrl: expectations are queued with the cycle
// at which they must hold and compared on the falling edge of that cycle.
module tb_menu_text_ctrl;

   localparam int TICK  = 4;
   localparam int BLINK = 2;
   localparam int T0    = 1;
   localparam int T1    = 60;
   localparam int T2    = 120;

   logic         clk = 1'b0;
   logic         rst = 1'b0;
   logic         sw = 1'b0, btn_l = 1'b0, btn_r = 1'b0, btn_u = 1'b0, btn_d = 1'b0;
   logic         ld_valid = 1'b0, start = 1'b0, cancel = 1'b0;
   logic [1:0]   ld_scent = 2'd0, ld_timer = 2'd0;
   logic [3:0]   temperature10 = 4'd0, temperature0 = 4'd0;
   logic [3:0]   humidity10 = 4'd0, humidity0 = 4'd0;
   logic [127:0] row1, row2;
   logic         upd, running, done;

   menu_text_ctrl #(
      .TICK_DIV(TICK), .BLINK_DIV(BLINK), .T0_MIN(T0), .T1_MIN(T1), .T2_MIN(T2)
   ) dut (
      .clk(clk), .rst(rst), .sw(sw),
      .btn_l(btn_l), .btn_r(btn_r), .btn_u(btn_u), .btn_d(btn_d),
      .ld_valid(ld_valid), .ld_scent(ld_scent), .ld_timer(ld_timer),
      .start(start), .cancel(cancel),
      .temperature10(temperature10), .temperature0(temperature0),
      .humidity10(humidity10), .humidity0(humidity0),
      .row1(row1), .row2(row2), .upd(upd), .running(running), .done(done)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int nChecks = 0;
   int nErrors = 0;
   int runStart = 0;

   typedef struct {
      string tag;
      int    at;
      string r1;
      string r2;
      int    upd;
      int    run;
      int    done;
   } exp_t;

   exp_t sbQ[$];

   string SP = "                ";

   function automatic string rowStr(input logic [127:0] r);
      string s;
      s = "";
      for (int i = 15; i >= 0; i--) s = {s, $sformatf("%c", r[i*8 +: 8])};
      return s;
   endfunction

   function automatic string scentName(input int s);
      case (s)
         1:       return "Woody    ";
         2:       return "Citrus   ";
         default: return "Cotton   ";
      endcase
   endfunction

   function automatic string menu1(input int s);
      return {"Scent: ", scentName(s)};
   endfunction

   function automatic string menu2(input int m);
      return $sformatf("Timer: %3dmin   ", m);
   endfunction

   function automatic string run1(input int s);
      return {"Run: ", scentName(s), "  "};
   endfunction

   // s = clocks spent counting before the displayed snapshot was taken
   function automatic string leftRow(input int s, input int mins);
      int rem;
      rem = mins * 60 - s / TICK;
      return $sformatf("Left: %03d%s%02d    ", rem / 60, ((s / BLINK) % 2) ? " " : ":", rem % 60);
   endfunction

   // Every comparison in the bench goes through here.
   task automatic checkOutput(input string tag, input string act, input string exp);
      nChecks++;
      if (act != exp) begin
         nErrors++;
         $display("[TB] FAIL %s: observed '%s' expected '%s'", tag, act, exp);
      end
   endtask

   task automatic pushExp(input string tag, input int at, input string r1, input string r2,
                          input int u, input int rn, input int d);
      exp_t e;
      e.tag = tag; e.at = at; e.r1 = r1; e.r2 = r2; e.upd = u; e.run = rn; e.done = d;
      sbQ.push_back(e);
   endtask

   task automatic expectAt(input string tag, input int delay, input string r1, input string r2,
                           input int u, input int rn, input int d);
      pushExp(tag, cyc + delay, r1, r2, u, rn, d);
   endtask

   task automatic expectRun(input string tag, input int p, input string r1, input int mins,
                            input int u, input int rn, input int d);
      pushExp(tag, runStart + p, r1, (r1 == "") ? "" : leftRow(p - 2, mins), u, rn, d);
   endtask

   // Advance n rising edges, then step just past the edge before touching inputs.
   task automatic applyStimulus(input int n);
      if (n > 0) repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic waitUntil(input int target);
      applyStimulus(target - cyc);
   endtask

   // Scoreboard: pop every expectation due in this cycle and compare it.
   always @(negedge clk) begin
      int   i;
      exp_t e;
      i = 0;
      while (i < sbQ.size()) begin
         if (sbQ[i].at <= cyc) begin
            e = sbQ[i];
            if (e.at < cyc) begin
               checkOutput({e.tag, "_cycle"}, $sformatf("%0d", cyc), $sformatf("%0d", e.at));
            end else begin
               if (e.r1 != "") checkOutput({e.tag, "_row1"}, rowStr(row1), e.r1);
               if (e.r2 != "") checkOutput({e.tag, "_row2"}, rowStr(row2), e.r2);
               if (e.upd >= 0)  checkOutput({e.tag, "_upd"}, $sformatf("%0d", upd), $sformatf("%0d", e.upd));
               if (e.run >= 0)  checkOutput({e.tag, "_running"}, $sformatf("%0d", running), $sformatf("%0d", e.run));
               if (e.done >= 0) checkOutput({e.tag, "_done"}, $sformatf("%0d", done), $sformatf("%0d", e.done));
            end
            sbQ.delete(i);
         end else begin
            i++;
         end
      end
   end

   initial begin
      #200000;
      $display("[TB] FAIL timeout: simulation did not finish within the time limit");
      $fatal(1, "[TB] timeout");
   end

   initial begin
      // Reset state and first update after release
      applyStimulus(2);
      expectAt("reset", 0, SP, SP, 0, 0, 0);
      applyStimulus(1);
      rst = 1'b1;
      expectAt("rel_pre", 0, SP, SP, 0, 0, 0);
      expectAt("rel_first", 1, menu1(0), menu2(T0), 1, 0, 0);
      expectAt("rel_steady", 2, menu1(0), menu2(T0), 0, 0, 0);
      applyStimulus(3);

      // Scent wraps upward through all three names
      btn_r = 1'b1;
      expectAt("btn_r1", 2, menu1(1), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      expectAt("btn_r2", 2, menu1(2), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      expectAt("btn_r3", 2, menu1(0), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      btn_r = 1'b0;
      expectAt("btn_r_quiet", 2, menu1(0), menu2(T0), 0, 0, 0);
      applyStimulus(3);

      // Timer wraps downward from index 0
      btn_d = 1'b1;
      expectAt("btn_d", 2, menu1(0), menu2(T2), 1, 0, 0);
      applyStimulus(1);
      btn_d = 1'b0;
      applyStimulus(2);

      // Scent wraps down, timer wraps up, same cycle
      btn_l = 1'b1; btn_u = 1'b1;
      expectAt("btn_lu", 2, menu1(2), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      btn_l = 1'b0; btn_u = 1'b0;
      applyStimulus(2);

      // Opposite buttons cancel each other
      btn_l = 1'b1; btn_r = 1'b1; btn_u = 1'b1; btn_d = 1'b1;
      expectAt("btn_opposite", 2, menu1(2), menu2(T0), 0, 0, 0);
      applyStimulus(1);
      btn_l = 1'b0; btn_r = 1'b0; btn_u = 1'b0; btn_d = 1'b0;
      applyStimulus(2);

      // Loads beat buttons; index 3 clamps to 2
      ld_valid = 1'b1; ld_scent = 2'd1; ld_timer = 2'd2; btn_r = 1'b1; btn_u = 1'b1;
      expectAt("load_prio", 2, menu1(1), menu2(T2), 1, 0, 0);
      applyStimulus(1);
      ld_valid = 1'b0; btn_r = 1'b0; btn_u = 1'b0;
      applyStimulus(2);
      ld_valid = 1'b1; ld_scent = 2'd3; ld_timer = 2'd3;
      expectAt("load_clamp", 2, menu1(2), menu2(T2), 1, 0, 0);
      applyStimulus(1);
      ld_valid = 1'b0;
      applyStimulus(2);
      ld_valid = 1'b1; ld_scent = 2'd0; ld_timer = 2'd1;
      expectAt("load_60", 2, menu1(0), menu2(T1), 1, 0, 0);
      applyStimulus(1);
      ld_valid = 1'b0;
      applyStimulus(2);
      ld_valid = 1'b1; ld_scent = 2'd0; ld_timer = 2'd0;
      expectAt("load_1", 2, menu1(0), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      ld_valid = 1'b0;
      applyStimulus(2);

      // Full one-minute countdown with blink, sensor page and ignored inputs
      runStart = cyc;
      start = 1'b1;
      expectRun("run_on", 1, "", T0, -1, 1, 0);
      expectRun("run_p2", 2, run1(0), T0, 1, 1, 0);
      expectRun("run_p3", 3, run1(0), T0, 0, 1, 0);
      expectRun("run_p4", 4, run1(0), T0, 1, 1, 0);
      expectRun("run_p5", 5, run1(0), T0, 0, 1, 0);
      expectRun("run_p6", 6, run1(0), T0, 1, 1, 0);
      expectRun("run_p16", 16, run1(0), T0, -1, 1, 0);
      expectRun("run_p100", 100, run1(0), T0, -1, 1, 0);
      expectRun("run_p240", 240, run1(0), T0, -1, 1, 0);
      expectRun("run_end", 241, "", T0, -1, 0, 1);
      pushExp("run_menu", runStart + 242, menu1(0), menu2(T0), 1, 0, 0);
      applyStimulus(1);
      start = 1'b0;

      waitUntil(runStart + 9);
      start = 1'b1; btn_r = 1'b1;
      applyStimulus(1);
      start = 1'b0; btn_r = 1'b0;

      waitUntil(runStart + 20);
      sw = 1'b1; temperature10 = 4'd2; temperature0 = 4'd5; humidity10 = 4'd4; humidity0 = 4'd10;
      expectAt("sensor_on", 1, "Temp: 25'C      ", "Humi: 4?%       ", 1, 1, 0);
      expectAt("sensor_hold", 5, "Temp: 25'C      ", "Humi: 4?%       ", 0, 1, 0);
      waitUntil(runStart + 30);
      temperature0 = 4'd6;
      expectAt("sensor_chg", 1, "Temp: 26'C      ", "Humi: 4?%       ", 1, 1, 0);
      waitUntil(runStart + 40);
      sw = 1'b0;
      expectRun("sensor_off", 41, run1(0), T0, 1, 1, 0);

      waitUntil(runStart + 245);

      // Cancel lands on a tick cycle; no done pulse
      ld_valid = 1'b1; ld_scent = 2'd0; ld_timer = 2'd1;
      applyStimulus(1);
      ld_valid = 1'b0;
      applyStimulus(2);
      runStart = cyc;
      start = 1'b1;
      expectRun("cancel_load", 2, run1(0), T1, 1, 1, 0);
      applyStimulus(1);
      start = 1'b0;
      waitUntil(runStart + 4);
      cancel = 1'b1;
      expectAt("cancel_pre", 0, "", "", -1, 1, 0);
      expectAt("cancel_fsm", 1, "", "", -1, 0, 0);
      expectAt("cancel_menu", 2, menu1(0), menu2(T1), 1, 0, 0);
      applyStimulus(1);
      cancel = 1'b0;
      applyStimulus(3);

      // Asynchronous reset in the middle of a countdown
      runStart = cyc;
      start = 1'b1;
      applyStimulus(1);
      start = 1'b0;
      waitUntil(runStart + 6);
      expectRun("rst_pre", 6, run1(0), T1, 1, 1, 0);
      applyStimulus(1);
      #2;
      rst = 1'b0;
      expectAt("rst_async", 0, SP, SP, 0, 0, 0);
      applyStimulus(2);
      rst = 1'b1;
      applyStimulus(3);

      checkOutput("sb_drain", $sformatf("%0d", sbQ.size()), "0");
      $display("Result: errors=%0d of %0d checks", nErrors, nChecks);
      $finish;
   end

endmodule

// File: doc/menu_text_ctrl.md
Name: menu_text_ctrl

Overview:
- Registered LCD text composer for the 16x2 character display. It replaces the combinational row builder.
- Owns the scent-select and timer-select state internally, so Bluetooth loads and button steps are arbitrated in one place.
- Adds a countdown "run" page with a blinking colon, and produces a one-cycle update strobe for the LCD write sequencer.
- Sits between the mode/UART logic and the I2C LCD driver.

Parameters:
- TICK_DIV, 50_000_000: clocks per countdown second.
- BLINK_DIV, 25_000_000: clocks per colon blink half-period.
- T0_MIN, 30: minutes for timer index 0 (range 1..999).
- T1_MIN, 60: minutes for timer index 1.
- T2_MIN, 120: minutes for timer index 2.

Ports:
- clk  in  1  system clock
- rst  in  1  asynchronous, active-low reset
- sw  in  1  1 = sensor page (display only, state keeps running)
- btn_l, btn_r  in  1  one-cycle pulses: scent index -1 / +1
- btn_u, btn_d  in  1  one-cycle pulses: timer index +1 / -1
- ld_valid  in  1  one-cycle pulse: load ld_scent/ld_timer (Bluetooth)
- ld_scent  in  2  scent index to load
- ld_timer  in  2  timer index to load
- start  in  1  one-cycle pulse: begin countdown
- cancel  in  1  one-cycle pulse: abort countdown
- temperature10, temperature0, humidity10, humidity0  in  4 each  BCD sensor digits
- row1, row2  out  128  ASCII rows, MSB = leftmost character
- upd  out  1  one-cycle pulse: rows changed
- running  out  1  countdown active
- done  out  1  one-cycle pulse: countdown reached 00:00

Behaviour:
- Reset (rst low, async): scent=0, timer=0, state IDLE, countdown=0, both blink/tick counters 0, blink phase 0.
  - Outputs on reset: row1=row2=16 spaces (8'h20), upd=0, running=0, done=0.
- Index state, IDLE only; ignored in RUN:
  - ld_valid has priority over all buttons in the same cycle. Index 3 in a load is clamped to 2.
  - Otherwise btn_l/btn_r step scent with wrap 0..2; btn_u/btn_d step timer with wrap 0..2.
  - Opposite buttons in the same cycle produce no change for that field.
- FSM IDLE -> RUN on start:
  - Load minutes = Tn_MIN as 3-digit BCD, seconds = 00; clear tick and blink counters; running=1.
  - start while already in RUN is ignored.
- RUN countdown:
  - Every TICK_DIV clocks, decrement BCD MMM:SS with borrow (00 -> 59 with minute borrow).
  - The decrement that reaches 000:00 returns to IDLE, pulses done for 1 cycle, and drops running.
- RUN -> IDLE on cancel: no done pulse; cancel has priority over a same-cycle tick.
- Blink: in RUN, the phase toggles every BLINK_DIV clocks; phase 1 shows ' ' in place of ':'. The phase is held at 0 in IDLE.
- Page select, in priority order: sw=1 -> sensor page; else RUN -> run page; else menu page.
- Page content (exactly 16 characters each):
  - Sensor row1: "Temp: " T10 T0 "'C      ". Sensor row2: "Humi: " H10 H0 "%       ".
  - Digits are value+8'h30. Digits >9 display as '?'.
  - Menu row1: "Scent: " + name. Name is "Cotton   ", "Woody    " or "Citrus   " (9 chars).
  - Menu row2: "Timer: " + 3-digit minutes with leading zeros blanked to spaces + "min   ".
  - Run row1: "Run: " + 9-char name + "  ".
  - Run row2: "Left: " + MMM (leading zeros kept) + ':'/' ' + SS + "    ".
- Latency: rows are registered, 1 clock after any state/input change.
- upd: pulses in the cycle the registered rows differ from the previous cycle's rows. It pulses on the first clock after reset release, because the rows change from spaces.
- Sensor page rows change when the digit inputs change. The countdown continues underneath.

Test Plan:
- Release reset, idle inputs -> row1="Scent: Cotton   ", row2="Timer:  30min   "; upd high exactly 1 cycle, 1 clock after release.
- btn_r x3 -> scent wraps Cotton->Woody->Citrus->Cotton, upd per change. btn_d once from 0 -> row2 shows "Timer: 120min   ".
- ld_valid with ld_scent=1, ld_timer=2, together with btn_r, in the same cycle -> scent=Woody (load wins), timer=120. A load with ld_scent=3 gives Citrus.
- Setup: TICK_DIV=4, BLINK_DIV=2, T0_MIN=1; start.
  - Expect row2="Left: 001:00    ", then "000:59" after 4 clocks, with the colon alternating every 2 clocks.
  - At "000:00": done pulses 1 cycle, running falls, and the menu page returns.
- During RUN, assert sw=1 -> sensor page shown (T=2,5 -> "Temp: 25'C      "). The countdown keeps decrementing. sw=0 shows the current Left value.
- During RUN, cancel in the same cycle as a tick -> IDLE, no done, menu rows. Assert rst low mid-RUN -> all outputs go to reset values immediately.
